// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a start bit, clocks out
// one odd-parity byte on device clock falls, then checks the device acknowledge.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES + 1);

    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SEND,
        S_ACK,
        S_WAITHI
    } state_t;

    state_t        state, state_nx;
    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [9:0]    frame, frame_nx;
    logic [3:0]    bit_cnt, bit_cnt_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          drive_low, drive_low_nx;

    logic clk_fall;
    logic clk_s;
    logic data_s;
    logic timed_out;

    // Both PS/2 lines are asynchronous; the clock gets a third stage for edge detection.
    assign clk_fall  = clk_sync[2] & ~clk_sync[1];
    assign clk_s     = clk_sync[1];
    assign data_s    = data_sync[1];
    assign timed_out = (timer == TIMEOUT_MAX);

    // NOTE: only control and datapath registers live here, and every one uses <= so
    // all of them update together from the values present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            clk_sync  <= '1;
            data_sync <= '1;
            frame     <= '0;
            bit_cnt   <= '0;
            timer     <= '0;
            drive_low <= 1'b0;
        end else begin
            state     <= state_nx;
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            frame     <= frame_nx;
            bit_cnt   <= bit_cnt_nx;
            timer     <= timer_nx;
            drive_low <= drive_low_nx;
        end
    end

    // NOTE: every signal written here is given a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nx     = state;
        frame_nx     = frame;
        bit_cnt_nx   = bit_cnt;
        timer_nx     = timer;
        drive_low_nx = drive_low;
        tx_done      = 1'b0;
        tx_err       = 1'b0;

        unique case (state)
            S_IDLE: begin
                drive_low_nx = 1'b0;
                if (tx_valid) begin
                    frame_nx   = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_nx = '0;
                    timer_nx   = '0;
                    state_nx   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (timer == INHIBIT_LAST) begin
                    timer_nx     = '0;
                    drive_low_nx = 1'b1;
                    state_nx     = S_START;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end

            S_START: begin
                timer_nx = '0;
                state_nx = S_SEND;
            end

            S_SEND, S_ACK, S_WAITHI: begin
                if (timed_out) begin
                    tx_err       = 1'b1;
                    drive_low_nx = 1'b0;
                    state_nx     = S_IDLE;
                end else begin
                    timer_nx = timer + 1'b1;
                    if (state == S_SEND) begin
                        // Frame shifts out LSB first; the tenth bit is the stop bit.
                        if (clk_fall) begin
                            drive_low_nx = ~frame[0];
                            frame_nx     = {1'b0, frame[9:1]};
                            bit_cnt_nx   = bit_cnt + 1'b1;
                            if (bit_cnt == 4'd9) state_nx = S_ACK;
                        end
                    end else if (state == S_ACK) begin
                        if (clk_fall) begin
                            if (!data_s) begin
                                state_nx = S_WAITHI;
                            end else begin
                                tx_err   = 1'b1;
                                state_nx = S_IDLE;
                            end
                        end
                    end else if (clk_s && data_s) begin
                        tx_done  = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
            end

            default: state_nx = S_IDLE;
        endcase
    end

    // Line enables decode straight from state, so an async reset releases both at once.
    assign ps2_clk_oe  = (state == S_INHIBIT) || (state == S_START);
    assign ps2_data_oe = drive_low && ((state == S_START) || (state == S_SEND));
    assign tx_ready    = (state == S_IDLE);
    assign tx_busy     = ~tx_ready;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks the frame and acks or nacks it,
// expected line bits and done/err outcomes are queued when each byte is offered.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 4000;

    typedef enum logic {OUT_DONE, OUT_ERR} outcome_t;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    logic dev_clk_low;
    logic dev_data_low;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;

    logic     exp_bits[$];
    outcome_t exp_out[$];

    int   m_inh, m_stc;
    logic m_rp, m_rn;
    bit   m_to;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    // Open-drain bus: either side pulling low wins.
    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Outcome scoreboard: every done/err pulse must match the next queued outcome.
    always @(negedge clk) begin
        outcome_t got, exp;
        if (tx_done || tx_err) begin
            if (tx_done) done_cnt++;
            if (tx_err)  err_cnt++;
            vectors++;
            if (tx_done && tx_err) begin
                miscompares++;
                $display("FAIL outcome_exclusive: done=1 err=1, required only one");
            end else if (exp_out.size() == 0) begin
                miscompares++;
                $display("FAIL outcome_unexpected: done=%0b err=%0b with nothing expected", tx_done, tx_err);
            end else begin
                got = tx_done ? OUT_DONE : OUT_ERR;
                exp = exp_out.pop_front();
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL outcome: got %s, required %s", got.name(), exp.name());
                end
            end
        end
    end

    task automatic push_frame(input logic [7:0] b, input outcome_t o);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        exp_bits.push_back(~^b);
        exp_bits.push_back(1'b1);
        exp_out.push_back(o);
    endtask

    // Offer one byte for a single cycle; returns just after the accepting edge.
    task automatic start_byte(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Device: samples the start bit, then 10 clock pulses, then an 11th with optional ack.
    task automatic device(input bit ack);
        int   n;
        logic got, exp;
        n = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 300) begin
            miscompares++;
            $display("FAIL device_wait: no start bit after %0d cycles, required fewer than 300", n);
        end else begin
            repeat (20) @(negedge clk);
            for (int k = 0; k < 11; k++) begin
                if (k != 0) begin
                    dev_clk_low = 1'b1;
                    repeat (20) @(negedge clk);
                    dev_clk_low = 1'b0;
                end
                got = ps2_data;
                vectors++;
                if (exp_bits.size() == 0) begin
                    miscompares++;
                    $display("FAIL line_bit%0d: got %0b with no bit expected", k, got);
                end else begin
                    exp = exp_bits.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL line_bit%0d: got %0b, required %0b", k, got, exp);
                    end
                end
                repeat (20) @(negedge clk);
            end
            if (ack) dev_data_low = 1'b1;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
        end
    endtask

    task automatic watch_frame(output int inh, output int stc, output logic rdy_pulse,
                               output logic rdy_next, output bit timed_out);
        inh       = 0;
        stc       = 0;
        rdy_pulse = 1'bx;
        timed_out = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (ps2_clk_oe && !ps2_data_oe) inh++;
            if (ps2_clk_oe && ps2_data_oe)  stc++;
            if (tx_done || tx_err) begin
                rdy_pulse = tx_ready;
                timed_out = 1'b0;
                break;
            end
        end
        @(negedge clk);
        rdy_next = tx_ready;
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack);
        push_frame(b, ack ? OUT_DONE : OUT_ERR);
        start_byte(b);
        fork
            device(ack);
            watch_frame(m_inh, m_stc, m_rp, m_rn, m_to);
        join
        vectors++;
        if (m_to) begin
            miscompares++;
            $display("FAIL frame_end_%02h: no done/err within 3000 cycles", b);
        end
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        #1;
        vectors++;
        if ({ps2_clk_oe, ps2_data_oe, tx_ready, tx_busy, tx_done, tx_err} !== 6'b001000) begin
            miscompares++;
            $display("FAIL reset_outputs: clk_oe,data_oe,ready,busy,done,err=%06b, required 001000",
                     {ps2_clk_oe, ps2_data_oe, tx_ready, tx_busy, tx_done, tx_err});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_led_cmd;
        int d0 = done_cnt, e0 = err_cnt;
        run_frame(8'hED, 1'b1);
        vectors++;
        if (m_inh !== INH) begin
            miscompares++;
            $display("FAIL t1_inhibit_len: clk_oe alone for %0d cycles, required %0d", m_inh, INH);
        end
        vectors++;
        if (m_stc !== 1) begin
            miscompares++;
            $display("FAIL t1_start_len: start bit under held clock %0d cycles, required 1", m_stc);
        end
        vectors++;
        if ((done_cnt - d0) !== 1 || (err_cnt - e0) !== 0) begin
            miscompares++;
            $display("FAIL t1_pulses: done=%0d err=%0d, required 1 and 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_low_parity;
        int d0 = done_cnt;
        run_frame(8'h01, 1'b1);
        vectors++;
        if (m_rp !== 1'b0 || m_rn !== 1'b1) begin
            miscompares++;
            $display("FAIL t2_ready: ready at done=%0b after=%0b, required 0 then 1", m_rp, m_rn);
        end
        vectors++;
        if ((done_cnt - d0) !== 1) begin
            miscompares++;
            $display("FAIL t2_done: %0d pulses, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_nack;
        int d0 = done_cnt, e0 = err_cnt;
        run_frame(8'hF4, 1'b0);
        vectors++;
        if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 1) begin
            miscompares++;
            $display("FAIL t3_pulses: done=%0d err=%0d, required 0 and 1", done_cnt - d0, err_cnt - e0);
        end
        vectors++;
        if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL t3_idle: clk_oe,data_oe,ready=%03b, required 001",
                     {ps2_clk_oe, ps2_data_oe, tx_ready});
        end
    endtask

    task automatic test_timeout;
        int n = 0, t = 0;
        exp_out.push_back(OUT_ERR);
        start_byte(8'h5A);
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        while (t < 5000) begin
            @(negedge clk);
            t++;
            if (tx_err) break;
        end
        vectors++;
        if (t !== TMO) begin
            miscompares++;
            $display("FAIL t4_timeout: err after %0d cycles in SEND, required %0d", t, TMO);
        end
        @(negedge clk);
        vectors++;
        if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL t4_idle: clk_oe,data_oe,ready=%03b, required 001",
                     {ps2_clk_oe, ps2_data_oe, tx_ready});
        end
    endtask

    task automatic test_busy_and_reset;
        int n = 0, d0, e0;
        push_frame(8'hA3, OUT_DONE);
        start_byte(8'hA3);
        fork
            device(1'b1);
            watch_frame(m_inh, m_stc, m_rp, m_rn, m_to);
            begin
                repeat (150) @(negedge clk);
                vectors++;
                if (tx_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL t5_busy_ready: ready=%0b mid-frame, required 0", tx_ready);
                end
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        vectors++;
        if (m_to || m_rn !== 1'b1) begin
            miscompares++;
            $display("FAIL t5_complete: timed_out=%0b ready_after=%0b, required 0 and 1", m_to, m_rn);
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL t5_no_queue: ready=%0b after frame, required 1", tx_ready);
        end

        // Second half: async reset in the middle of SEND.
        start_byte(8'h3C);
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        vectors++;
        if (ps2_data_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL t5_pre_reset: data_oe=%0b in SEND, required 1", ps2_data_oe);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            miscompares++;
            $display("FAIL t5_reset_release: clk_oe,data_oe=%02b, required 00", {ps2_clk_oe, ps2_data_oe});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 0 || tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL t5_reset_quiet: done=%0d err=%0d ready=%0b, required 0 0 1",
                     done_cnt - d0, err_cnt - e0, tx_ready);
        end
    endtask

    task automatic test_back_to_back;
        int   d0 = done_cnt;
        logic r_idle, r_acc;
        push_frame(8'hF4, OUT_DONE);
        push_frame(8'hFF, OUT_DONE);
        @(negedge clk);
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hFF;
        fork
            begin
                device(1'b1);
                device(1'b1);
            end
            begin
                watch_frame(m_inh, m_stc, m_rp, m_rn, m_to);
                r_idle = m_rn;
                @(negedge clk);
                r_acc    = tx_ready;
                tx_valid = 1'b0;
                vectors++;
                if (m_to || r_idle !== 1'b1 || r_acc !== 1'b0) begin
                    miscompares++;
                    $display("FAIL t6_reaccept: timed_out=%0b ready idle=%0b next=%0b, required 0 1 0",
                             m_to, r_idle, r_acc);
                end
                watch_frame(m_inh, m_stc, m_rp, m_rn, m_to);
            end
        join
        repeat (10) @(negedge clk);
        vectors++;
        if ((done_cnt - d0) !== 2 || tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL t6_two_frames: done=%0d ready=%0b, required 2 and 1", done_cnt - d0, tx_ready);
        end
    endtask

    initial begin
        test_reset();
        test_led_cmd();
        test_low_parity();
        test_nack();
        test_timeout();
        test_busy_and_reset();
        test_back_to_back();
        vectors++;
        if (exp_bits.size() !== 0 || exp_out.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d bits and %0d outcomes left, required 0 and 0",
                     exp_bits.size(), exp_out.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
